// File: rtl/mtr_ramp_ctrl.sv
// Motor speed ramp controller: slews signed left/right speed commands toward
// latched targets once per tick, holds at zero before a reversal, and runs a
// fast ramp-down on emergency stop.

// One speed channel: target latch, dwell counter, and the per-tick slew step.
module mtr_ramp_lane #(
  parameter int STEP       = 4,
  parameter int BRAKE_STEP = 32,
  parameter int ZERO_DWELL = 8,
  parameter int SPD_MAX    = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,      // en low: wipe everything
  input  logic               ld,       // latch ld_val as new target
  input  logic signed [10:0] ld_val,
  input  logic               tick,
  input  logic               run,
  input  logic               brake,
  output logic signed [10:0] spd,
  output logic               at_tgt_nxt // post-update value equals target, no dwell
);
  localparam int DW = (ZERO_DWELL < 1) ? 1 : $clog2(ZERO_DWELL + 1);
  localparam logic [DW-1:0]      DW_LOAD = DW'(ZERO_DWELL);
  localparam logic [11:0]        STEP_W  = 12'(STEP);
  localparam logic [11:0]        BRK_W   = 12'(BRAKE_STEP);
  localparam logic signed [10:0] MAXV    = 11'(SPD_MAX);
  localparam logic signed [10:0] MINV    = 11'(-SPD_MAX);

  logic signed [10:0] tgt_q, tgt_d, spd_q, spd_d, sat, eff;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic signed [11:0] diff;
  logic [11:0]        mag, delta, step_sz;

  // Saturate incoming target; -1024 folds to -SPD_MAX like any other overrange.
  always_comb begin
    sat = ld_val;
    if (ld_val > MAXV)      sat = MAXV;
    else if (ld_val < MINV) sat = MINV;
  end

  // Next-state for target, speed and dwell. Tick math uses the old target so a
  // strobe landing on a tick cycle only takes effect from the following tick.
  always_comb begin
    tgt_d   = tgt_q;
    spd_d   = spd_q;
    dwell_d = dwell_q;
    eff     = tgt_q;
    step_sz = STEP_W;
    diff    = '0;
    mag     = '0;
    delta   = '0;
    if (clr) begin
      tgt_d   = '0;
      spd_d   = '0;
      dwell_d = '0;
    end else begin
      if (ld)    tgt_d   = sat;
      if (brake) dwell_d = '0;
      if (tick && (run || brake)) begin
        if (run && dwell_q != '0) begin
          dwell_d = dwell_q - 1'b1;
        end else begin
          if (brake) begin
            eff     = '0;
            step_sz = BRK_W;
          end else if (spd_q != '0 && tgt_q != '0 && spd_q[10] != tgt_q[10]) begin
            eff = '0;   // reversal: come down to zero first
          end
          // 12-bit difference so +1023 -> -1023 cannot wrap
          diff  = {eff[10], eff} - {spd_q[10], spd_q};
          mag   = diff[11] ? $unsigned(-diff) : $unsigned(diff);
          delta = (mag < step_sz) ? mag : step_sz;
          spd_d = diff[11] ? (spd_q - delta[10:0]) : (spd_q + delta[10:0]);
          if (run && spd_q != '0 && spd_d == '0) dwell_d = DW_LOAD;
        end
      end
    end
  end

  assign at_tgt_nxt = (spd_d == tgt_d) && (dwell_d == '0);
  assign spd        = spd_q;

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q   <= '0;
      spd_q   <= '0;
      dwell_q <= '0;
    end else begin
      tgt_q   <= tgt_d;
      spd_q   <= spd_d;
      dwell_q <= dwell_d;
    end
  end
endmodule

module mtr_ramp_ctrl #(
  parameter int TICK_DIV   = 1024,
  parameter int STEP       = 4,
  parameter int BRAKE_STEP = 32,
  parameter int ZERO_DWELL = 8,
  parameter int SPD_MAX    = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               tgt_vld,
  input  logic signed [10:0] lft_tgt,
  input  logic signed [10:0] rght_tgt,
  input  logic               estop,
  output logic signed [10:0] lft_spd,
  output logic signed [10:0] rght_spd,
  output logic               settled,
  output logic [1:0]         state
);
  localparam int NUM_LANES = 2;   // lane 0 = left, lane 1 = right
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_RUN     = 2'b01;
  localparam logic [1:0] S_BRAKE   = 2'b10;
  localparam logic [1:0] S_STOPPED = 2'b11;

  logic [1:0]                  state_q, state_nxt;
  logic [CW-1:0]               cnt_q;
  logic                        tick, ld, settled_q;
  logic [NUM_LANES-1:0][10:0]  tgt_in, spd_out;
  logic [NUM_LANES-1:0]        at_tgt;

  assign tick   = (state_q != S_IDLE) && (cnt_q == CW'(TICK_DIV - 1));
  // estop and BRAKE both block latching; the strobe that wakes STOPPED latches too
  assign ld     = en && tgt_vld && !estop && (state_q != S_BRAKE);
  assign tgt_in = {rght_tgt, lft_tgt};

  // Mode sequencing; en low overrides everything including estop.
  always_comb begin
    state_nxt = state_q;
    if (!en) state_nxt = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:    state_nxt = S_RUN;
        S_RUN:     if (estop) state_nxt = S_BRAKE;
        S_BRAKE:   if (spd_out[0] == '0 && spd_out[1] == '0) state_nxt = S_STOPPED;
        S_STOPPED: if (tgt_vld && !estop) state_nxt = S_RUN;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Tick prescaler, parked at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt_q <= '0;
    else if (!en || state_q == S_IDLE)  cnt_q <= '0;
    else if (tick)                      cnt_q <= '0;
    else                                cnt_q <= cnt_q + 1'b1;
  end

  // State and settled flag; settled tracks the values being written this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      settled_q <= en && (state_nxt == S_RUN) && (&at_tgt);
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mtr_ramp_lane #(
      .STEP(STEP), .BRAKE_STEP(BRAKE_STEP),
      .ZERO_DWELL(ZERO_DWELL), .SPD_MAX(SPD_MAX)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (!en),
      .ld         (ld),
      .ld_val     ($signed(tgt_in[g])),
      .tick       (tick),
      .run        (state_q == S_RUN),
      .brake      (state_q == S_BRAKE),
      .spd        (spd_out[g]),
      .at_tgt_nxt (at_tgt[g])
    );
  end

  assign lft_spd  = $signed(spd_out[0]);
  assign rght_spd = $signed(spd_out[1]);
  assign settled  = settled_q;
  assign state    = state_q;
endmodule
